bus_arbiter: RTL and testbench

- Shares one single-port RAM (request/acknowledge, 1-cycle registered ack, wr_ni=1 read / 0 write) between NUM_CLIENTS requesters.
- Arbitration is round-robin. The block serialises one transaction at a time to the RAM and routes the read data and acknowledge back to the winning client.
- It sits between the client blocks and the RAM instance. It also times out a memory that never acknowledges.

---
 rtl/bus_arbiter.sv | 136 +++++++++++++
 tb/tb_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that serialises NUM_CLIENTS request/acknowledge clients onto
// one single-port RAM, with a timeout for a memory that never acknowledges.
`timescale 1ns/1ps
module bus_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT     = 15
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLIENTS-1:0]            rq,
  input  logic [NUM_CLIENTS-1:0]            wr_ni,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] address,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] dataW,
  output logic [NUM_CLIENTS-1:0]            ack,
  output logic                              err,
  output logic [DATA_WIDTH-1:0]             dataR,
  output logic [$clog2(NUM_CLIENTS)-1:0]    grant_id,
  output logic                              mem_rq,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic                              mem_wr_ni,
  output logic [DATA_WIDTH-1:0]             mem_dataW,
  input  logic                              mem_ack,
  input  logic [DATA_WIDTH-1:0]             mem_dataR
);
  localparam int GW = $clog2(NUM_CLIENTS);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;

  state_e                  state_q;
  logic [NUM_CLIENTS-1:0]  ack_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   dataR_q;
  logic [GW-1:0]           grant_q;
  logic [GW-1:0]           last_q;
  logic                    mem_rq_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_wr_ni_q;
  logic [DATA_WIDTH-1:0]   mem_dataW_q;
  logic [CW-1:0]           cnt_q;

  // Rotate requests so bit 0 is the client right after the last one served;
  // the lowest set bit of the rotated vector is then the round-robin winner.
  logic [2*NUM_CLIENTS-1:0] rq_rot;
  logic                     win_valid_d;
  logic [GW-1:0]            win_d;
  int                       win_off;
  int                       win_idx;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    rq_rot      = {rq, rq} >> (int'(last_q) + 1);
    win_valid_d = 1'b0;
    win_off     = 0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (rq_rot[k]) begin
        win_valid_d = 1'b1;
        win_off     = k;
      end
    end
    win_idx = int'(last_q) + 1 + win_off;
    if (win_idx >= NUM_CLIENTS) win_idx = win_idx - NUM_CLIENTS;
    win_d = GW'(win_idx);
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ack_q       <= '0;
      err_q       <= 1'b0;
      dataR_q     <= '0;
      grant_q     <= '0;
      last_q      <= GW'(NUM_CLIENTS - 1);
      mem_rq_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wr_ni_q <= 1'b1;
      mem_dataW_q <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= '0;
          err_q <= 1'b0;
          if (win_valid_d) begin
            mem_addr_q  <= address[int'(win_d)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_dataW_q <= dataW[int'(win_d)*DATA_WIDTH +: DATA_WIDTH];
            mem_wr_ni_q <= wr_ni[win_d];
            grant_q     <= win_d;
            last_q      <= win_d;
            mem_rq_q    <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_rq_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_ack) begin
            if (mem_wr_ni_q) dataR_q <= mem_dataR;
            err_q   <= 1'b0;
            ack_q   <= NUM_CLIENTS'(1) << grant_q;
            state_q <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            dataR_q <= '0;
            ack_q   <= NUM_CLIENTS'(1) << grant_q;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          ack_q   <= '0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign dataR       = dataR_q;
  assign grant_id    = grant_q;
  assign mem_rq      = mem_rq_q;
  assign mem_address = mem_addr_q;
  assign mem_wr_ni   = mem_wr_ni_q;
  assign mem_dataW   = mem_dataW_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected RAM requests and client
// acks into queues; a monitor branch pops and compares whenever the DUT presents one.
`timescale 1ns/1ps
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    rq;
  logic [N-1:0]    wr_ni;
  logic [N*AW-1:0] address;
  logic [N*DW-1:0] dataW;
  logic [N-1:0]    ack;
  logic            err;
  logic [DW-1:0]   dataR;
  logic [1:0]      grant_id;
  logic            mem_rq;
  logic [AW-1:0]   mem_address;
  logic            mem_wr_ni;
  logic [DW-1:0]   mem_dataW;
  logic            mem_ack;
  logic [DW-1:0]   mem_dataR;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered one-cycle acknowledge; ram_dead silences it entirely.
  logic          ram_dead = 1'b0;
  logic          late_ack = 1'b0;
  logic          ram_ack_q = 1'b0;
  logic [DW-1:0] ram_rd_q = '0;
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    ram_ack_q <= mem_rq && !ram_dead;
    if (mem_rq && !ram_dead) begin
      if (mem_wr_ni) ram_rd_q <= ram[mem_address];
      else           ram[mem_address] <= mem_dataW;
    end
  end
  assign mem_ack   = ram_ack_q | late_ack;
  assign mem_dataR = ram_rd_q;

  bus_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rq(rq), .wr_ni(wr_ni), .address(address), .dataW(dataW),
    .ack(ack), .err(err), .dataR(dataR), .grant_id(grant_id), .mem_rq(mem_rq),
    .mem_address(mem_address), .mem_wr_ni(mem_wr_ni), .mem_dataW(mem_dataW),
    .mem_ack(mem_ack), .mem_dataR(mem_dataR)
  );

  typedef struct { int client; logic err; logic [DW-1:0] data; int cyc; } ack_exp_t;
  typedef struct { logic [AW-1:0] addr; logic wr_ni; logic [DW-1:0] data; int cyc; } mem_exp_t;

  ack_exp_t ack_sb[$];
  mem_exp_t mem_sb[$];
  int tests = 0;
  int fails = 0;
  logic [N-1:0] pend = '0;
  logic [N-1:0] reraise_mask = '0;
  int reraise_left = 0;
  int c0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of client behaviour: drop rq on ack, optionally re-raise a cycle later.
  task automatic step();
    @(negedge clk);
    rq   = (rq & ~ack) | pend;
    pend = '0;
    for (int i = 0; i < N; i++)
      if (ack[i] && reraise_mask[i] && reraise_left > 0) begin
        pend[i] = 1'b1;
        reraise_left--;
      end
  endtask

  task automatic set_client(int i, logic wr, logic [AW-1:0] a, logic [DW-1:0] d);
    wr_ni[i]           = wr;
    address[i*AW +: AW] = a;
    dataW[i*DW +: DW]   = d;
  endtask

  task automatic push_ack(int client, logic e, logic [DW-1:0] d, int c);
    ack_sb.push_back('{client: client, err: e, data: d, cyc: c});
  endtask

  task automatic push_mem(logic [AW-1:0] a, logic wr, logic [DW-1:0] d, int c);
    mem_sb.push_back('{addr: a, wr_ni: wr, data: d, cyc: c});
  endtask

  task automatic wait_done(int max_cycles);
    int n = 0;
    while ((ack_sb.size() != 0 || mem_sb.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    if (ack_sb.size() != 0 || mem_sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL wait_timeout: got %0d acks and %0d mem requests still pending, expected 0",
               ack_sb.size(), mem_sb.size());
      ack_sb.delete();
      mem_sb.delete();
    end
    step();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ack"},      ack, 0);
    check({tag, "_err"},      err, 0);
    check({tag, "_dataR"},    dataR, 0);
    check({tag, "_grant"},    grant_id, 0);
    check({tag, "_mem_rq"},   mem_rq, 0);
    check({tag, "_mem_addr"}, mem_address, 0);
    check({tag, "_mem_wr_ni"}, mem_wr_ni, 1);
    check({tag, "_mem_dataW"}, mem_dataW, 0);
  endtask

  initial begin
    rq = '0; wr_ni = '1; address = '0; dataW = '0; rst_n = 1'b0;
    fork
      begin : monitor
        ack_exp_t ae;
        mem_exp_t me;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (ack !== '0) begin
              if (ack_sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got ack=%b, expected none", ack);
              end else begin
                ae = ack_sb.pop_front();
                check("ack_onehot", ack, 32'(1) << ae.client);
                check("ack_grant_id", grant_id, ae.client);
                check("ack_err", err, ae.err);
                check("ack_dataR", dataR, ae.data);
                check("ack_cycle", cyc, ae.cyc);
              end
            end
            if (mem_rq !== 1'b0) begin
              if (mem_sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_mem_rq: got mem_rq=%b, expected 0", mem_rq);
              end else begin
                me = mem_sb.pop_front();
                check("mem_address", mem_address, me.addr);
                check("mem_wr_ni", mem_wr_ni, me.wr_ni);
                check("mem_dataW", mem_dataW, me.data);
                check("mem_rq_cycle", cyc, me.cyc);
              end
            end
          end
        end
      end
      begin : stimulus
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Client 2 writes 0xA5 to address 3.
        step(); c0 = cyc;
        set_client(2, 1'b0, 4'd3, 8'hA5); rq[2] = 1'b1;
        push_mem(4'd3, 1'b0, 8'hA5, c0 + 1);
        push_ack(2, 1'b0, 8'h00, c0 + 3);
        wait_done(20);

        // Client 1 reads it back.
        step(); c0 = cyc;
        set_client(1, 1'b1, 4'd3, 8'h00); rq[1] = 1'b1;
        push_mem(4'd3, 1'b1, 8'h00, c0 + 1);
        push_ack(1, 1'b0, 8'hA5, c0 + 3);
        wait_done(20);

        // Fresh reset, then all four clients request in the same cycle.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        step(); c0 = cyc;
        set_client(0, 1'b0, 4'd5, 8'h3C);
        set_client(1, 1'b0, 4'd6, 8'h7E);
        set_client(2, 1'b1, 4'd5, 8'h00);
        set_client(3, 1'b1, 4'd6, 8'h00);
        rq = 4'b1111;
        push_mem(4'd5, 1'b0, 8'h3C, c0 + 1);  push_ack(0, 1'b0, 8'h00, c0 + 3);
        push_mem(4'd6, 1'b0, 8'h7E, c0 + 5);  push_ack(1, 1'b0, 8'h00, c0 + 7);
        push_mem(4'd5, 1'b1, 8'h00, c0 + 9);  push_ack(2, 1'b0, 8'h3C, c0 + 11);
        push_mem(4'd6, 1'b1, 8'h00, c0 + 13); push_ack(3, 1'b0, 8'h7E, c0 + 15);
        wait_done(40);

        // Clients 0 and 1 re-request after every ack: grants must alternate.
        step(); c0 = cyc;
        set_client(0, 1'b1, 4'd5, 8'h11);
        set_client(1, 1'b1, 4'd6, 8'h22);
        reraise_mask = 4'b0011; reraise_left = 4;
        rq = 4'b0011;
        for (int k = 0; k < 6; k++) begin
          if (k % 2 == 0) begin
            push_mem(4'd5, 1'b1, 8'h11, c0 + 1 + 4*k); push_ack(0, 1'b0, 8'h3C, c0 + 3 + 4*k);
          end else begin
            push_mem(4'd6, 1'b1, 8'h22, c0 + 1 + 4*k); push_ack(1, 1'b0, 8'h7E, c0 + 3 + 4*k);
          end
        end
        wait_done(60);
        reraise_mask = '0;

        // Dead RAM: timeout with err=1 and dataR cleared, then a late ack is ignored.
        ram_dead = 1'b1;
        step(); c0 = cyc;
        set_client(3, 1'b1, 4'd6, 8'h00); rq[3] = 1'b1;
        push_mem(4'd6, 1'b1, 8'h00, c0 + 1);
        push_ack(3, 1'b1, 8'h00, c0 + 2 + TO);
        wait_done(40);
        late_ack = 1'b1;
        step();
        late_ack = 1'b0;
        repeat (3) step();
        check("late_ack_no_ack", ack, 0);
        check("late_ack_no_mem_rq", mem_rq, 0);
        check("late_ack_grant", grant_id, 3);

        // Reset pulsed during WAIT aborts silently; next request is served normally.
        step(); c0 = cyc;
        set_client(2, 1'b0, 4'd7, 8'h99); rq[2] = 1'b1;
        push_mem(4'd7, 1'b0, 8'h99, c0 + 1);
        repeat (3) step();
        #1 rst_n = 1'b0; rq = '0;
        #1 check_reset_outputs("midreset");
        step();
        rst_n = 1'b1; ram_dead = 1'b0;
        repeat (2) step();
        check("midreset_no_ack", ack, 0);
        step(); c0 = cyc;
        set_client(1, 1'b1, 4'd3, 8'h00); rq[1] = 1'b1;
        push_mem(4'd3, 1'b1, 8'h00, c0 + 1);
        push_ack(1, 1'b0, 8'hA5, c0 + 3);
        wait_done(20);

        check("scoreboard_drained", ack_sb.size() + mem_sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    join
  end
endmodule
